// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Purpose  : Shared return-tag type and parameter defaults for the SRAM arbiter
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int c_latency_default     = 2;
    localparam int c_vid_run_max_default = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_VID  = 2'd2
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/sram_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sram_tag_pipe
// Purpose  : DEPTH-stage shift register carrying the owner of each SRAM return
// Revision : 1.0 - initial release
// ============================================================================
module sram_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = c_latency_default
) (
    input  logic clk,
    input  logic i_clear,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Shares one SRAM port between a CPU and a video fetcher
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int LATENCY     = c_latency_default,
    parameter int VID_RUN_MAX = c_vid_run_max_default
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_w,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_wb,
    output logic [7:0]  cpu_din,
    output logic        cpu_ready,
    input  logic        vid_req,
    input  logic [15:0] vid_address,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    output logic        vid_valid,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wb,
    output logic        mem_w,
    input  logic [7:0]  mem_din
);

    localparam int                 c_run_w   = (VID_RUN_MAX < 1) ? 1 : $clog2(VID_RUN_MAX + 1);
    localparam logic [c_run_w-1:0] c_run_max = c_run_w'(VID_RUN_MAX);
    localparam logic [c_run_w-1:0] c_run_one = c_run_w'(1);

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_run_w-1:0] r_run;
    logic               w_cpu_elig;
    logic               w_grant_cpu;
    logic               w_grant_vid;
    tag_t               w_issue_tag;
    tag_t               r_issue_tag;
    tag_t               w_pipe_tag;
    tag_t               w_ret_tag;
    logic [15:0]        r_mem_address;
    logic [7:0]         r_mem_wb;
    logic               r_mem_w;
    logic               r_vid_ack;
    logic               r_wr_ready;

    always_comb begin
        w_cpu_elig   = cpu_req && (r_state == C_IDLE);
        w_grant_cpu  = w_cpu_elig && (!vid_req || (r_run == c_run_max));
        w_grant_vid  = vid_req && !w_grant_cpu;
        w_issue_tag  = TAG_NONE;
        w_state_next = r_state;
        // Writes never come back from the SRAM, so they leave no tag behind.
        if (w_grant_cpu && !cpu_w) begin
            w_issue_tag = TAG_CPU;
        end else if (w_grant_vid) begin
            w_issue_tag = TAG_VID;
        end
        case (r_state)
            C_IDLE:  if (w_grant_cpu) w_state_next = C_WAIT;
            C_WAIT:  if (cpu_ready)   w_state_next = C_IDLE;
            default: w_state_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_address <= '0;
            r_mem_wb      <= '0;
            r_mem_w       <= 1'b0;
            r_vid_ack     <= 1'b0;
            r_wr_ready    <= 1'b0;
            r_issue_tag   <= TAG_NONE;
            r_run         <= '0;
        end else begin
            r_mem_w     <= w_grant_cpu && cpu_w;
            r_wr_ready  <= w_grant_cpu && cpu_w;
            r_vid_ack   <= w_grant_vid;
            r_issue_tag <= w_issue_tag;
            if (w_grant_cpu) begin
                r_mem_address <= cpu_address;
            end else if (w_grant_vid) begin
                r_mem_address <= vid_address;
            end
            if (w_grant_cpu && cpu_w) begin
                r_mem_wb <= cpu_wb;
            end
            // Counts video wins only while the CPU is actually asking.
            if (!cpu_req || w_grant_cpu) begin
                r_run <= '0;
            end else if (w_grant_vid && (r_run != c_run_max)) begin
                r_run <= r_run + c_run_one;
            end
        end
    end

    sram_tag_pipe #(
        .DEPTH (LATENCY)
    ) u_tag_pipe (
        .clk     (clock),
        .i_clear (reset),
        .i_tag   (r_issue_tag),
        .o_tag   (w_pipe_tag)
    );

    assign w_ret_tag   = reset ? TAG_NONE : w_pipe_tag;
    assign cpu_ready   = r_wr_ready || (w_ret_tag == TAG_CPU);
    assign cpu_din     = (w_ret_tag == TAG_CPU) ? mem_din : 8'h00;
    assign vid_valid   = (w_ret_tag == TAG_VID);
    assign vid_data    = vid_valid ? mem_din : 8'h00;
    assign vid_ack     = r_vid_ack;
    assign mem_address = r_mem_address;
    assign mem_wb      = r_mem_wb;
    assign mem_w       = r_mem_w;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed scoreboard bench for sram_arbiter with a 2-cycle SRAM
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
        bit          chk;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_w = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_wb = '0;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic        vid_req = 1'b0;
    logic [15:0] vid_address = '0;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic [15:0] mem_address;
    logic [7:0]  mem_wb;
    logic        mem_w;
    logic [7:0]  mem_din;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_d0 = '0;
    logic [7:0]  rd_d1 = '0;

    exp_t cpu_q[$];
    exp_t vid_q[$];
    exp_t ack_q[$];
    exp_t wr_q[$];
    exp_t e_mon;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    bit chk_zero = 1'b0;
    bit chk_end  = 1'b0;
    bit end_done = 1'b0;

    sram_arbiter #(
        .LATENCY     (LAT),
        .VID_RUN_MAX (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_w       (cpu_w),
        .cpu_address (cpu_address),
        .cpu_wb      (cpu_wb),
        .cpu_din     (cpu_din),
        .cpu_ready   (cpu_ready),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_ack     (vid_ack),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .mem_address (mem_address),
        .mem_wb      (mem_wb),
        .mem_w       (mem_w),
        .mem_din     (mem_din)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // SRAM: data for the address on the bus in cycle a appears in cycle a+2.
    assign mem_din = rd_d1;
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
        mem[16'h1234] = 8'hA5;
        mem[16'h2000] = 8'h21;
        mem[16'h3000] = 8'h31;
        mem[16'h4000] = 8'h41;
        mem[16'h4100] = 8'h42;
        mem[16'h5000] = 8'h51;
        for (int i = 0; i < 16; i++) mem[16'h8000 + i] = 8'h60 + 8'(i);
        forever begin
            @(posedge clock);
            rd_d1 = rd_d0;
            rd_d0 = mem[mem_address];
            if (mem_w) mem[mem_address] = mem_wb;
        end
    end

    task automatic report(input bit ok, input string name, input string got, input string exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (chk_zero) begin
            report({mem_w, mem_address, mem_wb, cpu_ready, vid_ack, vid_valid, cpu_din, vid_data} == '0,
                   "reset_outputs",
                   $sformatf("cyc=%0d mem_w=%b addr=%h wb=%h rdy=%b ack=%b val=%b din=%h vdata=%h",
                             cyc, mem_w, mem_address, mem_wb, cpu_ready, vid_ack, vid_valid, cpu_din, vid_data),
                   "all zero");
        end
        if (mem_w) begin
            if (wr_q.size() == 0) begin
                report(1'b0, "mem_w", $sformatf("write pulse at cyc=%0d", cyc), "no write");
            end else begin
                e_mon = wr_q.pop_front();
                report(mem_address == e_mon.addr && mem_wb == e_mon.data && cyc == e_mon.cyc, "mem_w",
                       $sformatf("addr=%h wb=%h cyc=%0d", mem_address, mem_wb, cyc),
                       $sformatf("addr=%h wb=%h cyc=%0d", e_mon.addr, e_mon.data, e_mon.cyc));
            end
        end
        if (vid_ack) begin
            if (ack_q.size() == 0) begin
                report(1'b0, "vid_ack", $sformatf("ack at cyc=%0d", cyc), "no ack");
            end else begin
                e_mon = ack_q.pop_front();
                report(mem_address == e_mon.addr && cyc == e_mon.cyc && !mem_w, "vid_ack",
                       $sformatf("addr=%h cyc=%0d mem_w=%b", mem_address, cyc, mem_w),
                       $sformatf("addr=%h cyc=%0d mem_w=0", e_mon.addr, e_mon.cyc));
            end
        end
        if (cpu_ready) begin
            if (cpu_q.size() == 0) begin
                report(1'b0, "cpu_ready", $sformatf("pulse at cyc=%0d din=%h", cyc, cpu_din), "no pulse");
            end else begin
                e_mon = cpu_q.pop_front();
                report(cyc == e_mon.cyc && (!e_mon.chk || cpu_din == e_mon.data) && !vid_valid, "cpu_ready",
                       $sformatf("din=%h cyc=%0d vid_valid=%b", cpu_din, cyc, vid_valid),
                       $sformatf("din=%h cyc=%0d vid_valid=0", e_mon.data, e_mon.cyc));
            end
        end
        if (vid_valid) begin
            if (vid_q.size() == 0) begin
                report(1'b0, "vid_valid", $sformatf("pulse at cyc=%0d data=%h", cyc, vid_data), "no pulse");
            end else begin
                e_mon = vid_q.pop_front();
                report(cyc == e_mon.cyc && vid_data == e_mon.data, "vid_valid",
                       $sformatf("data=%h cyc=%0d", vid_data, cyc),
                       $sformatf("data=%h cyc=%0d", e_mon.data, e_mon.cyc));
            end
        end
        if (chk_end && !end_done) begin
            end_done = 1'b1;
            report(cpu_q.size() == 0, "cpu_q_drained", $sformatf("%0d left", cpu_q.size()), "0 left");
            report(vid_q.size() == 0, "vid_q_drained", $sformatf("%0d left", vid_q.size()), "0 left");
            report(ack_q.size() == 0, "ack_q_drained", $sformatf("%0d left", ack_q.size()), "0 left");
            report(wr_q.size() == 0,  "wr_q_drained",  $sformatf("%0d left", wr_q.size()),  "0 left");
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_go(input bit w, input logic [15:0] a, input logic [7:0] d);
        cpu_req     = 1'b1;
        cpu_w       = w;
        cpu_address = a;
        cpu_wb      = d;
    endtask

    initial begin
        int n;
        // Reset and the first cycle after release.
        reset = 1'b1;
        step(); chk_zero = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); chk_zero = 1'b0;

        // CPU read: ready three cycles after the request.
        cpu_go(1'b0, 16'h1234, 8'h00);
        cpu_q.push_back('{16'h1234, 8'hA5, cyc + 3, 1'b1});
        repeat (4) step();
        cpu_req = 1'b0;
        step();

        // CPU write, then a video read of the same address issued right behind it.
        cpu_go(1'b1, 16'h0100, 8'h5A);
        wr_q.push_back('{16'h0100, 8'h5A, cyc + 1, 1'b1});
        cpu_q.push_back('{16'h0100, 8'h00, cyc + 1, 1'b0});
        step();
        vid_req = 1'b1; vid_address = 16'h0100;
        ack_q.push_back('{16'h0100, 8'h00, cyc + 1, 1'b1});
        vid_q.push_back('{16'h0100, 8'h5A, cyc + 3, 1'b1});
        step();
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (3) step();
        cpu_go(1'b0, 16'h0100, 8'h00);
        cpu_q.push_back('{16'h0100, 8'h5A, cyc + 3, 1'b1});
        repeat (4) step();
        cpu_req = 1'b0;
        step();

        // Starvation guard: four video grants while the CPU waits, then the CPU.
        n = cyc;
        vid_req = 1'b1; vid_address = 16'h2000;
        for (int g = 0; g < 10; g++) begin
            if (g != 6) begin
                ack_q.push_back('{16'h2000, 8'h00, n + g + 1, 1'b1});
                vid_q.push_back('{16'h2000, 8'h21, n + g + 3, 1'b1});
            end
        end
        step(); step();
        cpu_go(1'b0, 16'h3000, 8'h00);
        cpu_q.push_back('{16'h3000, 8'h31, n + 9, 1'b1});
        repeat (8) step();
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (4) step();

        // Simultaneous first request: video first, each return to its owner.
        vid_req = 1'b1; vid_address = 16'h4000;
        cpu_go(1'b0, 16'h4100, 8'h00);
        ack_q.push_back('{16'h4000, 8'h00, cyc + 1, 1'b1});
        vid_q.push_back('{16'h4000, 8'h41, cyc + 3, 1'b1});
        cpu_q.push_back('{16'h4100, 8'h42, cyc + 4, 1'b1});
        step();
        vid_req = 1'b0;
        repeat (4) step();
        cpu_req = 1'b0;
        repeat (3) step();

        // Reset one cycle after a CPU read grant: the return is discarded.
        cpu_go(1'b0, 16'h5000, 8'h00);
        step();
        reset = 1'b1; cpu_req = 1'b0;
        step(); chk_zero = 1'b1;
        step(); reset = 1'b0;
        step(); chk_zero = 1'b0;
        cpu_go(1'b0, 16'h1234, 8'h00);
        cpu_q.push_back('{16'h1234, 8'hA5, cyc + 3, 1'b1});
        repeat (4) step();
        cpu_req = 1'b0;
        step();

        // Streaming video: sixteen back-to-back fetches.
        for (int i = 0; i < 16; i++) begin
            vid_req = 1'b1; vid_address = 16'h8000 + 16'(i);
            ack_q.push_back('{16'h8000 + 16'(i), 8'h00, cyc + 1, 1'b1});
            vid_q.push_back('{16'h8000 + 16'(i), 8'h60 + 8'(i), cyc + 3, 1'b1});
            step();
        end
        vid_req = 1'b0;
        repeat (5) step();

        chk_end = 1'b1;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
